// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter between the pipeline and a multi-cycle unit for a single
// register-file write port, plus a pending-write scoreboard for decode hazards.
module regfile_wr_arb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p_valid_i,
  input  logic [AW-1:0] p_addr_i,
  input  logic [DW-1:0] p_data_i,
  output logic          p_ready_o,
  input  logic          m_valid_i,
  input  logic [AW-1:0] m_addr_i,
  input  logic [DW-1:0] m_data_i,
  output logic          m_ready_o,
  input  logic          mc_issue_i,
  input  logic [AW-1:0] mc_rd_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o,
  output logic          wen_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o
);
  localparam int NREG = 1 << AW;

  typedef enum logic {GNT_P = 1'b0, GNT_M = 1'b1} grant_e;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  grant_e          last_grant;
  logic [NREG-1:0] pending, pending_nxt;
  logic            p_xfer, m_xfer;
  wr_t             wr_q, wr_nxt;

  // Whoever did not win last time gets priority when both are requesting.
  assign p_ready_o = !rstn && (!m_valid_i || last_grant == GNT_M);
  assign m_ready_o = !rstn && (!p_valid_i || last_grant == GNT_P);
  assign p_xfer    = p_valid_i && p_ready_o;
  assign m_xfer    = m_valid_i && m_ready_o;

  always_comb begin
    wr_nxt = '{wen: 1'b0, addr: wr_q.addr, data: wr_q.data};
    if (p_xfer)
      wr_nxt = '{wen: (p_addr_i != '0), addr: p_addr_i, data: p_data_i};
    else if (m_xfer)
      wr_nxt = '{wen: (m_addr_i != '0), addr: m_addr_i, data: m_data_i};
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (m_xfer)
      pending_nxt[m_addr_i] = 1'b0;
    if (mc_issue_i && mc_rd_i != '0)
      pending_nxt[mc_rd_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      last_grant <= GNT_M;
      pending    <= '0;
      wr_q       <= '0;
    end else begin
      pending <= pending_nxt;
      wr_q    <= wr_nxt;
      if (p_xfer)
        last_grant <= GNT_P;
      else if (m_xfer)
        last_grant <= GNT_M;
    end
  end

  assign rs1_busy_o = !rstn && (rs1_addr_i != '0) && pending[rs1_addr_i];
  assign rs2_busy_o = !rstn && (rs2_addr_i != '0) && pending[rs2_addr_i];

  assign wen_o     = wr_q.wen;
  assign wr_addr_o = wr_q.addr;
  assign wr_data_o = wr_q.data;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed + random bench for regfile_wr_arb; expected writes are queued when
// stimulus is applied and popped after the following clock edge.
module tb_regfile_wr_arb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          p_valid_i, m_valid_i, mc_issue_i;
  logic [AW-1:0] p_addr_i, m_addr_i, mc_rd_i, rs1_addr_i, rs2_addr_i;
  logic [DW-1:0] p_data_i, m_data_i;
  logic          p_ready_o, m_ready_o, rs1_busy_o, rs2_busy_o, wen_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;

  regfile_wr_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .p_valid_i(p_valid_i), .p_addr_i(p_addr_i), .p_data_i(p_data_i), .p_ready_o(p_ready_o),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_ready_o(m_ready_o),
    .mc_issue_i(mc_issue_i), .mc_rd_i(mc_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .wen_o(wen_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_assert = 0;
  int  n_fail = 0;

  // Reference model state
  logic            mdl_grant_m;
  logic [31:0]     mdl_pend;
  logic [AW-1:0]   mdl_addr;
  logic [DW-1:0]   mdl_data;

  // Readies/busies seen during the last cycle, for directed checks afterwards
  logic obs_pr, obs_mr, obs_b1, obs_b2;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic iss, input logic [AW-1:0] rd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    rstn = rst; p_valid_i = pv; p_addr_i = pa; p_data_i = pd;
    m_valid_i = mv; m_addr_i = ma; m_data_i = md;
    mc_issue_i = iss; mc_rd_i = rd; rs1_addr_i = r1; rs2_addr_i = r2;
  endtask

  // Evaluate one clock cycle with the currently driven inputs.
  task automatic cyc();
    logic ep, em, eb1, eb2, px, mx;
    wr_t  e, got;
    #1;
    ep  = !rstn && (!m_valid_i || mdl_grant_m);
    em  = !rstn && (!p_valid_i || !mdl_grant_m);
    eb1 = !rstn && rs1_addr_i != '0 && mdl_pend[rs1_addr_i];
    eb2 = !rstn && rs2_addr_i != '0 && mdl_pend[rs2_addr_i];
    obs_pr = p_ready_o; obs_mr = m_ready_o; obs_b1 = rs1_busy_o; obs_b2 = rs2_busy_o;
    chk("p_ready", DW'(p_ready_o), DW'(ep));
    chk("m_ready", DW'(m_ready_o), DW'(em));
    chk("rs1_busy", DW'(rs1_busy_o), DW'(eb1));
    chk("rs2_busy", DW'(rs2_busy_o), DW'(eb2));
    px = p_valid_i && ep;
    mx = m_valid_i && em;
    if (rstn) begin
      mdl_addr = '0; mdl_data = '0;
      e = '0;
    end else if (px) begin
      mdl_addr = p_addr_i; mdl_data = p_data_i;
      e = '{wen: (p_addr_i != '0), addr: p_addr_i, data: p_data_i};
    end else if (mx) begin
      mdl_addr = m_addr_i; mdl_data = m_data_i;
      e = '{wen: (m_addr_i != '0), addr: m_addr_i, data: m_data_i};
    end else begin
      e = '{wen: 1'b0, addr: mdl_addr, data: mdl_data};
    end
    sb.push_back(e);
    if (rstn) begin
      mdl_grant_m = 1'b1; mdl_pend = '0;
    end else begin
      if (px) mdl_grant_m = 1'b0;
      else if (mx) mdl_grant_m = 1'b1;
      if (mx) mdl_pend[m_addr_i] = 1'b0;
      if (mc_issue_i && mc_rd_i != '0) mdl_pend[mc_rd_i] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = '{wen: wen_o, addr: wr_addr_o, data: wr_data_o};
      e = sb.pop_front();
      chk("wen", DW'(got.wen), DW'(e.wen));
      chk("wr_addr", DW'(got.addr), DW'(e.addr));
      chk("wr_data", got.data, e.data);
    end
  endtask

  initial begin
    mdl_grant_m = 1'b1; mdl_pend = '0; mdl_addr = '0; mdl_data = '0;

    // Reset for two cycles
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(); cyc();
    chk("rst_wen", DW'(wen_o), 32'd0);
    chk("rst_addr", DW'(wr_addr_o), 32'd0);

    // Pipeline-only write
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("p_only_ready", DW'(obs_pr), 32'd1);
    chk("p_only_data", wr_data_o, 32'hDEADBEEF);
    chk("p_only_wen", DW'(wen_o), 32'd1);

    // Idle: wen drops, address/data hold
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("idle_hold_data", wr_data_o, 32'hDEADBEEF);

    // Contention after a fresh reset: P, M, P, M
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, AW'(i + 1), 32'h100 + i, 1, AW'(i + 20), 32'h200 + i, 0, 0, 0, 0);
      cyc();
      chk("rr_p_ready", DW'(obs_pr), DW'((i % 2) == 0));
      chk("rr_m_ready", DW'(obs_mr), DW'((i % 2) == 1));
      chk("rr_wen", DW'(wen_o), 32'd1);
    end

    // Issue rd 7; busy until the multi-cycle write to 7 lands
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cyc();
    chk("busy7_same_cycle", DW'(obs_b1), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    cyc();
    chk("busy7_set", DW'(obs_b1), 32'd1);
    drive(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
    cyc();
    chk("busy7_at_xfer", DW'(obs_b1), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    cyc();
    chk("busy7_cleared", DW'(obs_b1), 32'd0);

    // Same-cycle issue and writeback to 9: bit stays set
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    cyc();
    drive(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9);
    cyc();
    chk("set_clr_ready", DW'(obs_mr), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    cyc();
    chk("set_wins_busy9", DW'(obs_b2), 32'd1);

    // Multi-cycle write to r0: handshake completes, no write
    drive(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
    cyc();
    chk("r0_ready", DW'(obs_mr), 32'd1);
    chk("r0_wen", DW'(wen_o), 32'd0);

    // Issue to r0 is ignored; repeat issue to a pending rd is harmless
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    cyc();

    // Reset with pending 3 and 12 and a pipeline request waiting
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 3, 12);
    cyc();
    chk("pre_rst_busy3", DW'(obs_b1), 32'd1);
    drive(1, 1, 4, 32'hCAFE, 0, 0, 0, 0, 0, 3, 12);
    cyc();
    chk("rst_p_ready", DW'(obs_pr), 32'd0);
    chk("rst_busy3", DW'(obs_b1), 32'd0);
    chk("rst_busy12", DW'(obs_b2), 32'd0);
    chk("rst_no_write", DW'(wen_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 12);
    cyc();
    chk("post_rst_busy3", DW'(obs_b1), 32'd0);
    chk("post_rst_busy12", DW'(obs_b2), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0),
            1'($urandom), AW'($urandom), $urandom,
            1'($urandom), AW'($urandom), $urandom,
            ($urandom_range(0, 2) == 0), AW'($urandom),
            AW'($urandom), AW'($urandom));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (32 architectural registers).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset; synchronous, active-high (asserted = 1).
REQ-005 SHALL have ports p_valid_i/p_addr_i/p_data_i, input, 1/AW/DW, pipeline writeback request.
REQ-006 SHALL have port p_ready_o, output, 1, pipeline request accepted this cycle when high with p_valid_i.
REQ-007 SHALL have ports m_valid_i/m_addr_i/m_data_i, input, 1/AW/DW, multi-cycle unit writeback request.
REQ-008 SHALL have port m_ready_o, output, 1, multi-cycle request accepted this cycle when high with m_valid_i.
REQ-009 SHALL have ports mc_issue_i/mc_rd_i, input, 1/AW, multi-cycle op issued with destination mc_rd_i.
REQ-010 SHALL have ports rs1_addr_i/rs2_addr_i, input, AW, source addresses from decode.
REQ-011 SHALL have ports rs1_busy_o/rs2_busy_o, output, 1, source register has a pending multi-cycle write.
REQ-012 SHALL have ports wen_o/wr_addr_o/wr_data_o, output, 1/AW/DW, registered regfile write port.

Function
REQ-013 SHALL define a transfer as valid and ready high in the same cycle; at most one transfer per cycle.
REQ-014 SHALL drive p_ready_o = 1 when m_valid_i = 0 or last_grant = M; m_ready_o = 1 when p_valid_i = 0 or last_grant = P.
REQ-015 SHALL, with both valids high, assert exactly one ready, selected round-robin by last_grant.
REQ-016 SHALL update last_grant to the winning requester on every transfer; hold it otherwise.
REQ-017 SHALL register a transfer: wen_o/wr_addr_o/wr_data_o reflect the transfer one cycle later (latency 1).
REQ-018 SHALL drive wen_o = 0 in any cycle following no transfer; wr_addr_o/wr_data_o hold their previous values.
REQ-019 SHALL accept (complete handshake for) a transfer with address 0 but drive wen_o = 0 for it.
REQ-020 SHALL keep a 2^AW-bit pending mask; mc_issue_i with mc_rd_i != 0 sets pending[mc_rd_i]; mc_rd_i = 0 is ignored.
REQ-021 SHALL clear pending[m_addr_i] on every multi-cycle transfer.
REQ-022 SHALL, when set and clear target the same address in one cycle, leave the bit set.
REQ-023 SHALL treat repeat issue to an already-pending address as a no-op (no counting; one outstanding op per rd).
REQ-024 SHALL drive rsN_busy_o = pending[rsN_addr_i] combinationally, forced 0 when rsN_addr_i = 0.
REQ-025 SHALL not depend on requesters holding data stable after a transfer; inputs are sampled only at the transfer edge.
REQ-026 SHALL allow a requester to drop valid without a transfer; no state changes in that case.

Reset
REQ-027 SHALL, with rstn = 1 at a clock edge, clear pending to 0, set last_grant = M, and drive wen_o = 0, wr_addr_o = 0, wr_data_o = 0.
REQ-028 SHALL discard any in-progress handshake on reset; a transfer coinciding with reset produces no write.
REQ-029 SHALL, while rstn = 1, force p_ready_o = m_ready_o = 0 and rs1_busy_o = rs2_busy_o = 0.

Verification
REQ-030 SHALL cover: p only, addr 5, data 0xDEADBEEF -> p_ready_o = 1; next cycle wen_o = 1, wr_addr_o = 5, wr_data_o = 0xDEADBEEF.
REQ-031 SHALL cover: after reset, p and m valid every cycle for 4 cycles -> grants P, M, P, M; four writes on consecutive cycles.
REQ-032 SHALL cover: mc_issue_i with rd 7, rs1_addr_i = 7 -> rs1_busy_o = 1 until m transfer to 7; rs1_busy_o = 0 the cycle after.
REQ-033 SHALL cover: same-cycle mc_issue_i rd 9 and m transfer to 9 -> pending[9] stays 1, rs2_busy_o = 1 with rs2_addr_i = 9.
REQ-034 SHALL cover: m transfer to addr 0 with data 0x1234 -> m_ready_o = 1, next cycle wen_o = 0.
REQ-035 SHALL cover: reset asserted with pending bits 3 and 12 set and p valid -> no write, all busy 0 and readies 0 during reset, pending empty after.
